wiener_calc_mc: RTL
===================

Name: wiener_calc_mc

Overview:
- Parametrised, multi-channel successor of the single-channel Wiener pixel calculator.
- Latches per-channel block statistics, then computes one Wiener gain per channel with a shared serial divider.
- Filters a block of TOTAL_SAMPLES multi-channel pixels with a valid/ready handshake.
- Sits between the block-statistics unit and the block reassembly/output stage; tracks block and frame boundaries.

Parameters:
- DATA_WIDTH, 8, bits per channel sample.
- CHANNELS, 3, channels per pixel (packed, channel 0 in LSBs).
- TOTAL_SAMPLES, 64, pixels per block.
- GAIN_FRAC, 8, fractional bits of the gain; the gain is GAIN_FRAC+1 bits wide, unsigned.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stats_ready  in  1  statistics valid; sampled in IDLE only
- mean_of_block  in  CHANNELS*2*DATA_WIDTH  per-channel block mean
- variance_of_block  in  CHANNELS*2*DATA_WIDTH  per-channel block variance
- noise_variance  in  2*DATA_WIDTH  noise variance shared by all channels
- bypass  in  1  sampled with stats; 1 = pass pixels unchanged
- blocks_per_frame  in  32  blocks per frame; 0 is treated as 1
- data_in  in  CHANNELS*DATA_WIDTH  input pixel
- data_in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts pixels
- stats_busy  out  1  high whenever not IDLE
- data_out  out  CHANNELS*DATA_WIDTH  filtered pixel
- data_out_valid  out  1  data_out valid
- data_count_out  out  32  outputs emitted in the current block
- block_done  out  1  pulse with the last output of a block
- frame_done  out  1  pulse with the last output of a frame

Behaviour:
- Reset (async, active-low): state IDLE. All outputs 0. Gains 0. Block counter 0. Pipeline valids cleared, so an in-flight block is discarded without a done pulse.
- States:
  - IDLE: stats_ready=1 latches the means, variances, noise_variance and bypass; data_count_out clears; next state is CALC, or STREAM if bypass=1.
  - CALC: computes the gains channel by channel.
  - STREAM: accepts pixels.
  - On the TOTAL_SAMPLES-th accepted pixel, STREAM returns to IDLE.
  - stats_ready outside IDLE is ignored.
- Mean saturation: a mean above 2^DATA_WIDTH-1 is clamped to 2^DATA_WIDTH-1 when latched.
- Gain per channel: g = ((var-noise)<<GAIN_FRAC)/var when var>noise, else 0. var=0 gives 0. The result is always at most 2^GAIN_FRAC.
- Divider: restoring, one quotient bit per clock, GAIN_FRAC+1 clocks per channel, channels in order 0..CHANNELS-1. CALC lasts exactly CHANNELS*(GAIN_FRAC+1) cycles.
- in_ready timing: in_ready=1 only in STREAM. It rises CHANNELS*(GAIN_FRAC+1)+1 clocks after the accepting edge, or 1 clock after it in bypass. It falls on the edge that accepts the last pixel.
- Accept: a pixel is accepted on a clock where data_in_valid && in_ready. Gaps in data_in_valid are allowed and stall nothing else.
- Pixel math per channel:
  - d = in - mean, signed DATA_WIDTH+1 bits.
  - p = g*d, signed.
  - out = mean + ((p + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC).
  - out is clamped to [0, 2^DATA_WIDTH-1].
  - In bypass, out = in.
- Pipeline: 2 stages (multiply, then add/round/clamp). data_out_valid is asserted exactly 2 clocks after the accepting edge, in order, 1 output per accept.
- data_count_out increments with each data_out_valid and holds its value (TOTAL_SAMPLES after the last output) until the next stats accept.
- Block end: block_done pulses on the cycle of the TOTAL_SAMPLES-th data_out_valid.
- Frame tracking:
  - The block counter increments on block_done.
  - When it reaches blocks_per_frame, frame_done pulses together with block_done and the counter returns to 0.
  - blocks_per_frame is sampled at every block_done.
- Overlap: a new stats_ready is accepted in IDLE even while the previous block's last 2 outputs are draining. The drain still completes and both done pulses fire; data_count_out clears on the accepting edge, after the drain output is counted.

Test Plan:
- DW=8, GF=8, 1 channel. mean=0x80, var=0x40, noise=0x20 gives g=128. Stream 0xC0, 0xC1, 0x00 -> data_out 0xA0, 0xA1, 0x40. in_ready high 10 clocks after stats accept. Each output 2 clocks after its accept.
- CHANNELS=3. Channel 1 has noise ≥ var; channel 2 has var=0 -> channels 1 and 2 output their means exactly. Channel 0 is filtered as above. CALC lasts 27 cycles.
- bypass=1 with 64 pixels 0x00..0x3F -> data_out equals data_in. in_ready 1 clock after accept. data_count_out ends at 64, block_done on the 64th output.
- blocks_per_frame=2, two back-to-back blocks -> block_done twice, frame_done only on block 2. A third block gives no frame_done until block 4.
- Random data_in_valid gaps (about 50% duty) -> exactly 64 outputs. Order preserved. stats_ready pulsed mid-STREAM is ignored.
- Assert rst_n low in mid-STREAM after 20 pixels -> all outputs 0 immediately. No block_done. The next block starts cleanly with data_count_out from 0.

Source files
------------

// File: rtl/wiener_calc_mc_if.sv
// Statistics, pixel-stream and status bundle for the multi-channel Wiener calculator.
interface wiener_calc_mc_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CHANNELS   = 3
);
  logic                             stats_ready;
  logic [CHANNELS*2*DATA_WIDTH-1:0] mean_of_block;
  logic [CHANNELS*2*DATA_WIDTH-1:0] variance_of_block;
  logic [2*DATA_WIDTH-1:0]          noise_variance;
  logic                             bypass;
  logic [31:0]                      blocks_per_frame;
  logic [CHANNELS*DATA_WIDTH-1:0]   data_in;
  logic                             data_in_valid;
  logic                             in_ready;
  logic                             stats_busy;
  logic [CHANNELS*DATA_WIDTH-1:0]   data_out;
  logic                             data_out_valid;
  logic [31:0]                      data_count_out;
  logic                             block_done;
  logic                             frame_done;

  modport master (
    output stats_ready, mean_of_block, variance_of_block, noise_variance, bypass,
           blocks_per_frame, data_in, data_in_valid,
    input  in_ready, stats_busy, data_out, data_out_valid, data_count_out,
           block_done, frame_done
  );

  modport slave (
    input  stats_ready, mean_of_block, variance_of_block, noise_variance, bypass,
           blocks_per_frame, data_in, data_in_valid,
    output in_ready, stats_busy, data_out, data_out_valid, data_count_out,
           block_done, frame_done
  );
endinterface

// File: rtl/wiener_calc_mc.sv
// Multi-channel Wiener pixel calculator: latches block statistics, derives one
// gain per channel with a shared restoring divider, then filters a block of pixels.
module wiener_calc_mc #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned TOTAL_SAMPLES = 64,
  parameter int unsigned GAIN_FRAC     = 8
) (
  input logic              clk,
  input logic              rst_n,
  wiener_calc_mc_if.slave  bus
);
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned GF    = GAIN_FRAC;
  localparam int unsigned VW    = 2 * DW;
  localparam int unsigned RW    = VW + 1;
  localparam int unsigned GW    = GF + 1;
  localparam int unsigned PW    = GF + DW + 3;
  localparam int unsigned XW    = CHANNELS * DW;
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned BIT_W = $clog2(GF + 1);
  localparam int unsigned CNT_W = $clog2(TOTAL_SAMPLES + 1);
  localparam logic [DW-1:0]        MAX_PIX = '1;
  localparam logic signed [PW-1:0] RND     = PW'(2 ** (GF - 1));

  typedef enum logic [1:0] {IDLE, CALC, STREAM} state_t;

  state_t            state, state_next;
  logic [DW-1:0]     mean_q [CHANNELS];
  logic [VW-1:0]     var_q  [CHANNELS];
  logic [GW-1:0]     gain_q [CHANNELS];
  logic [VW-1:0]     noise_q;
  logic              bypass_q;
  logic [CH_W-1:0]   div_ch;
  logic [BIT_W-1:0]  div_bit;
  logic [RW-1:0]     div_rem;
  logic [GF-1:0]     div_q;
  logic [CNT_W-1:0]  pix_cnt;
  logic              tag_q;
  logic [31:0]       blk_cnt;

  logic              s0_valid, s0_last, s0_tag, s0_byp;
  logic [XW-1:0]     s0_pix;
  logic              s1_valid, s1_last, s1_tag, s1_byp;
  logic [XW-1:0]     s1_pix;
  logic signed [PW-1:0] s1_p    [CHANNELS];
  logic [DW-1:0]        s1_mean [CHANNELS];

  logic stats_acc, pix_acc, pix_last, calc_done;
  assign stats_acc = (state == IDLE) && bus.stats_ready;
  assign pix_acc   = bus.data_in_valid && bus.in_ready;
  assign pix_last  = pix_acc && (pix_cnt == CNT_W'(TOTAL_SAMPLES - 1));
  assign calc_done = (state == CALC) && (div_bit == BIT_W'(GF)) && (div_ch == CH_W'(CHANNELS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.stats_ready) state_next = bus.bypass ? STREAM : CALC;
      CALC:    if (calc_done)       state_next = STREAM;
      STREAM:  if (pix_last)        state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Mean saturation ahead of the statistics latch
  logic [DW-1:0] mean_sat [CHANNELS];
  logic [VW-1:0] mean_fld;
  always_comb begin
    mean_fld = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mean_fld    = bus.mean_of_block[c*VW +: VW];
      mean_sat[c] = (mean_fld > VW'(MAX_PIX)) ? MAX_PIX : mean_fld[DW-1:0];
    end
  end

  // Statistics latch, taken only on the IDLE accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mean_q[c] <= '0;
        var_q[c]  <= '0;
      end
      noise_q  <= '0;
      bypass_q <= 1'b0;
    end else if (stats_acc) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mean_q[c] <= mean_sat[c];
        var_q[c]  <= bus.variance_of_block[c*VW +: VW];
      end
      noise_q  <= bus.noise_variance;
      bypass_q <= bus.bypass;
    end
  end

  // One restoring-division step; a channel with var <= noise yields all-zero bits
  logic [VW-1:0] div_var;
  logic [RW-1:0] div_cur, div_diff;
  logic          div_ok, div_bit_val;
  always_comb begin
    div_var     = var_q[div_ch];
    div_ok      = div_var > noise_q;
    div_cur     = (div_bit == '0) ? (div_ok ? RW'(div_var - noise_q) : '0) : div_rem;
    div_bit_val = div_ok && (div_cur >= RW'(div_var));
    div_diff    = div_bit_val ? (div_cur - RW'(div_var)) : div_cur;
  end

  // Divider sequencing and gain write-back, channel 0 first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) gain_q[c] <= '0;
      div_ch  <= '0;
      div_bit <= '0;
      div_rem <= '0;
      div_q   <= '0;
    end else if (stats_acc) begin
      div_ch  <= '0;
      div_bit <= '0;
    end else if (state == CALC) begin
      div_rem <= {div_diff[RW-2:0], 1'b0};
      div_q   <= GF'({div_q, div_bit_val});
      if (div_bit == BIT_W'(GF)) begin
        gain_q[div_ch] <= {div_q, div_bit_val};
        div_bit        <= '0;
        div_ch         <= CH_W'(div_ch + 1'b1);
      end else begin
        div_bit <= BIT_W'(div_bit + 1'b1);
      end
    end
  end

  // Per-block pixel counter and block tag (tag separates drain outputs from the new block)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      tag_q   <= 1'b0;
    end else if (stats_acc) begin
      pix_cnt <= '0;
      tag_q   <= ~tag_q;
    end else if (pix_acc) begin
      pix_cnt <= CNT_W'(pix_cnt + 1'b1);
    end
  end

  // Signed difference and gain product per channel
  logic signed [DW:0]   d_c [CHANNELS];
  logic signed [PW-1:0] p_c [CHANNELS];
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      d_c[c] = $signed({1'b0, s0_pix[c*DW +: DW]}) - $signed({1'b0, mean_q[c]});
      p_c[c] = PW'($signed({1'b0, gain_q[c]})) * PW'(d_c[c]);
    end
  end

  // Round, re-add mean and clamp to the pixel range
  logic [XW-1:0]        out_c;
  logic signed [PW-1:0] r_c;
  logic [DW-1:0]        o_c;
  always_comb begin
    out_c = '0;
    r_c   = '0;
    o_c   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      r_c = ((s1_p[c] + RND) >>> GF) + PW'($signed({1'b0, s1_mean[c]}));
      if (r_c[PW-1])            o_c = '0;
      else if (|r_c[PW-2:DW])   o_c = MAX_PIX;
      else                      o_c = r_c[DW-1:0];
      out_c[c*DW +: DW] = s1_byp ? s1_pix[c*DW +: DW] : o_c;
    end
  end

  // Input capture, multiply stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0; s0_last <= 1'b0; s0_tag <= 1'b0; s0_byp <= 1'b0; s0_pix <= '0;
      s1_valid <= 1'b0; s1_last <= 1'b0; s1_tag <= 1'b0; s1_byp <= 1'b0; s1_pix <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        s1_p[c]    <= '0;
        s1_mean[c] <= '0;
      end
    end else begin
      s0_valid <= pix_acc;
      if (pix_acc) begin
        s0_pix  <= bus.data_in;
        s0_last <= pix_last;
        s0_tag  <= tag_q;
        s0_byp  <= bypass_q;
      end
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_pix  <= s0_pix;
        s1_last <= s0_last;
        s1_tag  <= s0_tag;
        s1_byp  <= s0_byp;
        for (int c = 0; c < CHANNELS; c++) begin
          s1_p[c]    <= p_c[c];
          s1_mean[c] <= mean_q[c];
        end
      end
    end
  end

  // Registered outputs, output count and frame tracking
  logic [31:0] bpf_c;
  assign bpf_c = (bus.blocks_per_frame == 32'd0) ? 32'd1 : bus.blocks_per_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.in_ready       <= 1'b0;
      bus.stats_busy     <= 1'b0;
      bus.data_out       <= '0;
      bus.data_out_valid <= 1'b0;
      bus.data_count_out <= '0;
      bus.block_done     <= 1'b0;
      bus.frame_done     <= 1'b0;
      blk_cnt            <= '0;
    end else begin
      bus.in_ready       <= (state == STREAM) && !pix_last;
      bus.stats_busy     <= (state_next != IDLE);
      bus.data_out_valid <= s1_valid;
      bus.block_done     <= s1_valid && s1_last;
      bus.frame_done     <= 1'b0;
      if (s1_valid) bus.data_out <= out_c;
      if (stats_acc)                       bus.data_count_out <= '0;
      else if (s1_valid && s1_tag == tag_q) bus.data_count_out <= 32'(bus.data_count_out + 32'd1);
      if (s1_valid && s1_last) begin
        if (32'(blk_cnt + 32'd1) >= bpf_c) begin
          bus.frame_done <= 1'b1;
          blk_cnt        <= '0;
        end else begin
          blk_cnt <= 32'(blk_cnt + 32'd1);
        end
      end
    end
  end
endmodule
